bch_syndrome_accum_p32: RTL and testbench

Sequential syndrome accumulator for the 32-bit-parallel BCH decoder over GF(2^13). It sits directly downstream of the column constant-multiplier bank and the XOR reduction that follows it. Each beat it receives eight 13-bit partial syndrome terms covering 32 codeword bits, and folds them into eight running syndromes with a Horner update. After the final beat it presents the syndromes, plus zero and length-error flags, to the key-equation (Euclidean) stage through a valid/ready handshake.

---
 rtl/bch_syndrome_accum_p32_if.sv | 26 ++
 rtl/bch_syndrome_accum_p32.sv | 126 ++++++++++++
 tb/tb_bch_syndrome_accum_p32.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bch_syndrome_accum_p32_if.sv
// Beat input and syndrome output handshakes of the BCH syndrome accumulator.
// The master side is the upstream term producer together with the key-equation consumer.
interface bch_syndrome_accum_p32_if #(
    parameter int M = 13
);
    logic             din_valid;
    logic             din_ready;
    logic             sof;
    logic             eof;
    logic [8*M-1:0]   term_in;
    logic [8*M-1:0]   syn_out;
    logic             syn_valid;
    logic             syn_ready;
    logic             zero_flag;
    logic             len_err;

    modport master (
        output din_valid, sof, eof, term_in, syn_ready,
        input  din_ready, syn_out, syn_valid, zero_flag, len_err
    );

    modport slave (
        input  din_valid, sof, eof, term_in, syn_ready,
        output din_ready, syn_out, syn_valid, zero_flag, len_err
    );
endinterface

// File: rtl/bch_syndrome_accum_p32.sv
// Horner accumulation of eight BCH syndromes over GF(2^M), PAR codeword bits per beat.
// state | meaning:  IDLE wait for sof | ACCUM fold beats | DONE hold syndromes until syn_ready
module bch_syndrome_accum_p32 #(
    parameter int             M         = 13,
    parameter logic [M-1:0]   PRIM_POLY = 13'h001B,
    parameter int             PAR       = 32,
    parameter int             N_BEATS   = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bch_syndrome_accum_p32_if.slave   bus
);

    localparam int CW = $clog2(N_BEATS + 1);
    localparam logic [CW-1:0] N_CNT = CW'(N_BEATS);

    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] v);
        logic [M-1:0] r;
        r = {v[M-2:0], 1'b0};
        if (v[M-1]) r = r ^ PRIM_POLY;
        return r;
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int e);
        logic [M-1:0] r;
        r = M'(1);
        for (int i = 0; i < e; i++) r = mul_alpha(r);
        return r;
    endfunction

    // Constant operand c folds to a fixed XOR matrix: column j is c*alpha^j.
    function automatic logic [M-1:0] mul_const(input logic [M-1:0] a, input logic [M-1:0] c);
        logic [M-1:0] acc;
        logic [M-1:0] col;
        acc = '0;
        col = c;
        for (int j = 0; j < M; j++) begin
            if (a[j]) acc = acc ^ col;
            col = mul_alpha(col);
        end
        return acc;
    endfunction

    localparam logic [8*M-1:0] A_PACK = {
        alpha_pow(PAR * 15), alpha_pow(PAR * 13), alpha_pow(PAR * 11), alpha_pow(PAR * 9),
        alpha_pow(PAR * 7),  alpha_pow(PAR * 5),  alpha_pow(PAR * 3),  alpha_pow(PAR * 1)
    };

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t          state, state_nxt;
    logic [8*M-1:0]  syn_q, syn_d, horner;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic            zero_q, zero_nxt;
    logic            len_q, len_nxt;
    logic            accept;

    assign bus.din_ready = (state != DONE);
    assign bus.syn_valid = (state == DONE);
    assign bus.syn_out   = syn_q;
    assign bus.zero_flag = zero_q;
    assign bus.len_err   = len_q;

    assign accept  = bus.din_valid && bus.din_ready;
    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        horner = '0;
        for (int k = 0; k < 8; k++) begin
            horner[k*M +: M] = mul_const(syn_q[k*M +: M], A_PACK[k*M +: M]) ^ bus.term_in[k*M +: M];
        end
    end

    always_comb begin
        state_nxt = state;
        syn_d     = syn_q;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        zero_nxt  = zero_q;

        if (accept) begin
            // sof restarts from either IDLE or ACCUM; the aborted codeword is dropped.
            if (bus.sof) begin
                syn_d   = bus.term_in;
                cnt_nxt = CW'(1);
                if (bus.eof) begin
                    state_nxt = DONE;
                    len_nxt   = (N_BEATS != 1);
                end else begin
                    state_nxt = ACCUM;
                end
            end else if (state == ACCUM) begin
                syn_d   = horner;
                cnt_nxt = cnt_inc;
                if (bus.eof) begin
                    state_nxt = DONE;
                    len_nxt   = (cnt_inc != N_CNT);
                end else if (cnt_inc == N_CNT) begin
                    state_nxt = DONE;
                    len_nxt   = 1'b1;
                end
            end
        end

        if (state == DONE && bus.syn_ready) state_nxt = IDLE;

        if (state != DONE && state_nxt == DONE) zero_nxt = ~|syn_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            syn_q  <= '0;
            cnt    <= '0;
            zero_q <= 1'b0;
            len_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            syn_q  <= syn_d;
            cnt    <= cnt_nxt;
            zero_q <= zero_nxt;
            len_q  <= len_nxt;
        end
    end

endmodule

// File: tb/tb_bch_syndrome_accum_p32.sv
// Directed bench: a short-codeword instance (N_BEATS=4) driven from a vector table and a
// full-length instance (N_BEATS=256) exercised by hand-written sequences.
module tb_bch_syndrome_accum_p32;
    localparam int M = 13;
    typedef logic [8*M-1:0] bus_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic din_valid = 1'b0, sof = 1'b0, eof = 1'b0, syn_rdy = 1'b1;
    bus_t term = '0;

    bch_syndrome_accum_p32_if #(.M(M)) if4 ();
    bch_syndrome_accum_p32_if #(.M(M)) if256 ();

    assign if4.din_valid   = din_valid;
    assign if4.sof         = sof;
    assign if4.eof         = eof;
    assign if4.term_in     = term;
    assign if4.syn_ready   = syn_rdy;
    assign if256.din_valid = din_valid;
    assign if256.sof       = sof;
    assign if256.eof       = eof;
    assign if256.term_in   = term;
    assign if256.syn_ready = syn_rdy;

    bch_syndrome_accum_p32 #(.N_BEATS(4))   dut4   (.clk(clk), .rst_n(rst_n), .bus(if4));
    bch_syndrome_accum_p32 #(.N_BEATS(256)) dut256 (.clk(clk), .rst_n(rst_n), .bus(if256));

    int n_cmp = 0;
    int n_bad = 0;
    int vcount = 0;
    always @(posedge clk) if (if256.syn_valid) vcount <= vcount + 1;

    logic [M-1:0] a_tb [8];
    logic [M-1:0] ms [8];
    bit           m_started;

    typedef struct {
        int           nb;
        logic [3:0]   sof_m;
        logic [3:0]   eof_m;
        logic [M-1:0] b [4];
        logic [M-1:0] s1;
        bit           z;
        bit           le;
    } vec_t;
    vec_t tbl [10];

    // Full carry-less product followed by reduction by x^13+x^4+x^3+x+1.
    function automatic logic [M-1:0] gmul(logic [M-1:0] a, logic [M-1:0] b);
        logic [2*M-2:0] p;
        p = '0;
        for (int i = 0; i < M; i++) if (b[i]) p = p ^ ((2*M-1)'(a) << i);
        for (int i = 2*M-2; i >= M; i--) if (p[i]) p = p ^ ((2*M-1)'(14'h201B) << (i - M));
        return p[M-1:0];
    endfunction

    function automatic bus_t make_term(logic [M-1:0] b);
        bus_t t;
        for (int k = 0; k < 8; k++) t[k*M +: M] = (b == '0) ? '0 : (b ^ M'(k));
        return t;
    endfunction

    function automatic bus_t rand_term();
        bus_t t;
        for (int k = 0; k < 8; k++) t[k*M +: M] = M'($urandom);
        return t;
    endfunction

    function automatic bus_t model_pack();
        bus_t t;
        for (int k = 0; k < 8; k++) t[k*M +: M] = ms[k];
        return t;
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        for (int k = 0; k < 8; k++) ms[k] = '0;
    endtask

    task automatic model_beat(bit s, bus_t t);
        if (s) begin
            m_started = 1'b1;
            for (int k = 0; k < 8; k++) ms[k] = t[k*M +: M];
        end else if (m_started) begin
            for (int k = 0; k < 8; k++) ms[k] = gmul(ms[k], a_tb[k]) ^ t[k*M +: M];
        end
    endtask

    function automatic logic get_ready(int sel);
        return (sel != 0) ? if256.din_ready : if4.din_ready;
    endfunction
    function automatic logic get_valid(int sel);
        return (sel != 0) ? if256.syn_valid : if4.syn_valid;
    endfunction
    function automatic bus_t get_syn(int sel);
        return (sel != 0) ? if256.syn_out : if4.syn_out;
    endfunction
    function automatic logic get_zero(int sel);
        return (sel != 0) ? if256.zero_flag : if4.zero_flag;
    endfunction
    function automatic logic get_len(int sel);
        return (sel != 0) ? if256.len_err : if4.len_err;
    endfunction

    task automatic chk(string nm, bus_t act, bus_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat's accepting edge.
    task automatic send_beat(int sel, bit s, bit e, bus_t t);
        int n;
        din_valid = 1'b1;
        sof = s;
        eof = e;
        term = t;
        n = 0;
        while (!get_ready(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: din_ready stayed 0 for %0d cycles, expected 1", n);
        end
        model_beat(s, t);
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        sof = 1'b0;
        eof = 1'b0;
    endtask

    task automatic check_out(int sel, string tag, logic [M-1:0] s1, bit use_s1, bit z, bit le);
        bus_t s;
        s = get_syn(sel);
        chk({tag, "_valid"}, bus_t'(get_valid(sel)), bus_t'(1'b1));
        chk({tag, "_syn"}, s, model_pack());
        if (use_s1) chk({tag, "_s1"}, bus_t'(s[M-1:0]), bus_t'(s1));
        chk({tag, "_zero"}, bus_t'(get_zero(sel)), bus_t'(z));
        chk({tag, "_len"}, bus_t'(get_len(sel)), bus_t'(le));
    endtask

    task automatic handshake(int sel, string tag);
        syn_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_drop"}, bus_t'(get_valid(sel)), bus_t'(1'b0));
        chk({tag, "_ready_rise"}, bus_t'(get_ready(sel)), bus_t'(1'b1));
    endtask

    task automatic set_vec(int i, int nb, logic [3:0] sm, logic [3:0] em,
                           logic [M-1:0] b0, logic [M-1:0] b1, logic [M-1:0] b2, logic [M-1:0] b3,
                           logic [M-1:0] s1, bit z, bit le);
        tbl[i].nb = nb;
        tbl[i].sof_m = sm;
        tbl[i].eof_m = em;
        tbl[i].b[0] = b0;
        tbl[i].b[1] = b1;
        tbl[i].b[2] = b2;
        tbl[i].b[3] = b3;
        tbl[i].s1 = s1;
        tbl[i].z = z;
        tbl[i].le = le;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [M-1:0] p;
        int vbase;
        for (int k = 0; k < 8; k++) begin
            p = M'(1);
            repeat (32 * (2 * k + 1)) p = gmul(p, M'(2));
            a_tb[k] = p;
        end

        // N_BEATS=4 vectors: {beats, sof mask, eof mask, base term per beat, S_1, zero, len_err}
        set_vec(0, 2, 4'b0001, 4'b0010, 13'h0001, 13'h0000, 13'h0000, 13'h0000, 13'h1176, 1'b0, 1'b1);
        set_vec(1, 4, 4'b0001, 4'b1000, 13'h0000, 13'h0000, 13'h0000, 13'h0000, 13'h0000, 1'b1, 1'b0);
        set_vec(2, 1, 4'b0001, 4'b0001, 13'h0ABC, 13'h0000, 13'h0000, 13'h0000, 13'h0ABC, 1'b0, 1'b1);
        set_vec(3, 3, 4'b0001, 4'b0100, 13'h0000, 13'h0000, 13'h0005, 13'h0000, 13'h0005, 1'b0, 1'b1);
        set_vec(4, 4, 4'b0001, 4'b1000, 13'h0000, 13'h0000, 13'h0000, 13'h1FFF, 13'h1FFF, 1'b0, 1'b0);
        set_vec(5, 4, 4'b0001, 4'b0000, 13'h0000, 13'h0000, 13'h0001, 13'h0000, 13'h1176, 1'b0, 1'b1);
        set_vec(6, 4, 4'b0001, 4'b1000, 13'h0000, 13'h0000, 13'h0001, 13'h0001, 13'h1177, 1'b0, 1'b0);
        set_vec(7, 3, 4'b0010, 4'b0100, 13'h0007, 13'h0001, 13'h0000, 13'h0000, 13'h1176, 1'b0, 1'b1);
        set_vec(8, 4, 4'b0101, 4'b1000, 13'h0007, 13'h0003, 13'h0001, 13'h0000, 13'h1176, 1'b0, 1'b1);
        set_vec(9, 2, 4'b0001, 4'b0010, 13'h0000, 13'h0000, 13'h0000, 13'h0000, 13'h0000, 1'b1, 1'b1);

        @(negedge clk);
        chk("rst_valid", bus_t'(if4.syn_valid), '0);
        chk("rst_syn", if4.syn_out, '0);
        chk("rst_zero", bus_t'(if4.zero_flag), '0);
        chk("rst_len", bus_t'(if4.len_err), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus_t'(if4.din_ready), bus_t'(1'b1));

        for (int i = 0; i < 10; i++) begin
            model_reset();
            for (int j = 0; j < tbl[i].nb; j++)
                send_beat(0, tbl[i].sof_m[j], tbl[i].eof_m[j], make_term(tbl[i].b[j]));
            check_out(0, $sformatf("vec%0d", i), tbl[i].s1, 1'b1, tbl[i].z, tbl[i].le);
            handshake(0, $sformatf("vec%0d", i));
        end

        // Back-pressure in DONE with a sof beat held on the input.
        syn_rdy = 1'b0;
        model_reset();
        send_beat(0, 1'b1, 1'b0, make_term(13'h0002));
        send_beat(0, 1'b0, 1'b1, make_term(13'h0000));
        check_out(0, "stall", 13'h02F7, 1'b1, 1'b0, 1'b1);
        din_valid = 1'b1;
        sof = 1'b1;
        term = make_term(13'h0001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_ready", i), bus_t'(if4.din_ready), '0);
            chk($sformatf("stall%0d_valid", i), bus_t'(if4.syn_valid), bus_t'(1'b1));
            chk($sformatf("stall%0d_syn", i), if4.syn_out, model_pack());
        end
        handshake(0, "stall");
        model_reset();
        send_beat(0, 1'b1, 1'b0, make_term(13'h0001));
        send_beat(0, 1'b0, 1'b1, make_term(13'h0000));
        check_out(0, "after_stall", 13'h1176, 1'b1, 1'b0, 1'b1);
        handshake(0, "after_stall");

        // Full-length instance.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vbase = vcount;
        model_reset();
        for (int i = 0; i < 3; i++) send_beat(1, i == 0, 1'b0, rand_term());
        for (int i = 0; i < 256; i++) send_beat(1, i == 0, i == 255, rand_term());
        check_out(1, "abort", '0, 1'b0, model_pack() == '0, 1'b0);
        handshake(1, "abort");
        chk("abort_valid_count", bus_t'(vcount - vbase), bus_t'(1));

        model_reset();
        for (int i = 0; i < 256; i++) send_beat(1, i == 0, i == 255, '0);
        check_out(1, "zero256", '0, 1'b1, 1'b1, 1'b0);
        handshake(1, "zero256");

        model_reset();
        for (int i = 0; i < 100; i++) send_beat(1, i == 0, 1'b0, rand_term());
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus_t'(if256.syn_valid), '0);
        chk("midrst_syn", if256.syn_out, '0);
        chk("midrst_zero", bus_t'(if256.zero_flag), '0);
        chk("midrst_len", bus_t'(if256.len_err), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        for (int i = 0; i < 256; i++) send_beat(1, i == 0, i == 255, rand_term());
        check_out(1, "post_rst", '0, 1'b0, model_pack() == '0, 1'b0);
        handshake(1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
